lsu_axi_ctrl: RTL and testbench
===============================

Name: lsu_axi_ctrl

Overview:
Parametrised load/store unit sitting between EXU and WBU. It drives a single AXI4-Lite master port through an explicit FSM with registered request capture, and carries no combinational path from the request to the bus. It generalises data width and the full-width (SRAM) address window, and generates byte strobes internally from funct3. It adds misalignment detection, bus-error reporting, and independent tracking of the AW and W handshakes.

Parameters:
DATA_W, 32, AXI data width in bits; legal values 32 or 64.
ADDR_W, 32, address width in bits.
FW_BASE, 32'h0f000000, inclusive base of the full-width window.
FW_LIMIT, 32'h10000000, exclusive limit of the full-width window.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low (0 = reset)
req_valid  in  1  EXU request valid
req_ready  out  1  LSU idle; request accepted when req_valid & req_ready
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  RISC-V load/store funct3
req_addr  in  ADDR_W  effective address
req_wdata  in  DATA_W  store data, right-aligned
rsp_valid  out  1  one-cycle completion pulse to WBU
rsp_rdata  out  DATA_W  extended load data; 0 for stores and errors
rsp_err  out  1  bus error (resp != OKAY) or unsupported funct3
rsp_misalign  out  1  misaligned access; no bus transaction issued
araddr/arsize/arvalid  out  ADDR_W/3/1  AXI read address channel
arready  in  1  AXI read address ready
rdata/rresp/rvalid  in  DATA_W/2/1  AXI read data channel
rready  out  1  AXI read data ready
awaddr/awsize/awvalid  out  ADDR_W/3/1  AXI write address channel
awready  in  1  AXI write address ready
wdata/wstrb/wvalid  out  DATA_W/(DATA_W/8)/1  AXI write data channel
wready  in  1  AXI write data ready
bresp/bvalid  in  2/1  AXI write response channel
bready  out  1  AXI write response ready

Behaviour:
- Reset (rst=0 at a clock edge): state IDLE; all valids/readies and rsp_* outputs = 0; latched request cleared. Reset mid-transaction abandons it with no response.
- FSM states: IDLE, AR, R, AWW, B, RSP.
- IDLE: req_ready=1. On accept, latch addr/we/funct3/wdata.
  - Illegal funct3 (ld/lwu/sd when DATA_W=32; loads 3'b111; stores >3'b011) -> RSP with err=1.
  - Misaligned (h: addr[0]; w: addr[1:0]; d: addr[2:0] nonzero) -> RSP with misalign=1.
  - Otherwise load -> AR, store -> AWW.
- AR: arvalid=1 until arready, then R.
- R: rready=1; on rvalid, capture extended data and err = (rresp!=0); go to RSP.
- AWW: awvalid and wvalid rise together. Each drops on its own handshake; handshakes may complete in either order or in the same cycle. Go to B once both are done.
- B: bready=1; on bvalid, err = (bresp!=0); go to RSP.
- RSP: rsp_valid=1 for exactly one cycle, then IDLE. WBU always accepts; no response backpressure.
- Full-width window (FW_BASE <= addr < FW_LIMIT):
  - address aligned down to DATA_W/8; size = log2(DATA_W/8).
  - wdata shifted to lane addr[log2(DATA_W/8)-1:0]; wstrb = access mask << lane offset.
  - load data extracted from that lane.
- Outside the window: unaligned address passed through; size = access size; data and strb in lane 0.
- Extension: funct3[2]=0 sign-extends, 1 zero-extends, to DATA_W.
- Latency with zero-wait slave: load accepted at cycle 0 -> arvalid cycle 1 -> R cycle 2 -> rsp_valid cycle 3. Misaligned or illegal request -> rsp_valid at cycle 1.
- AXI outputs are stable while valid is high without ready.

Decomposition:
- Shared package lsu_pkg: state enum, funct3 constants (LB..LD, SB..SD), AXI resp constants, size encodings.
- One combinational sub-module lsu_lane_align: lane shift, strobe generation and load extraction/extension, parametrised by DATA_W.

Test Plan:
1. DATA_W=32, lbu addr 0x0f000003, rdata 0xA1B2C3D4 -> araddr 0x0f000000, arsize 2, rsp_rdata 0x000000A1.
2. sh addr 0x0f000002, wdata 0x1234 -> awaddr 0x0f000000, wdata 0x12340000, wstrb 4'b1100.
3. sb to 0x10000000 (UART), wdata 0x41 -> awaddr 0x10000000, awsize 0, wstrb 4'b0001. Then awready 2 cycles before wready -> single B wait, one rsp_valid.
4. lw addr 0x0f000002 -> no arvalid; rsp_valid cycle 1 with rsp_misalign=1.
5. lh addr 0x0f000000, rresp=2'b10, rdata 0x8000 -> rsp_err=1, rsp_rdata 0.
6. DATA_W=64, ld addr 0x0f000008, rdata 0x8877665544332211 -> full value returned. Separately, assert rst=0 during AR -> arvalid 0 next cycle, no rsp_valid.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the LSU / AXI4-Lite master.
// Also holds the funct3 legality and alignment helpers used at request accept.
package lsu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_AR,
    S_R,
    S_AWW,
    S_B,
    S_RSP
  } state_e;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LD  = 3'b011;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] LWU = 3'b110;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;
  localparam logic [2:0] SD  = 3'b011;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [2:0] SIZE_B = 3'd0;
  localparam logic [2:0] SIZE_H = 3'd1;
  localparam logic [2:0] SIZE_W = 3'd2;
  localparam logic [2:0] SIZE_D = 3'd3;

  function automatic logic f3_legal(input logic we, input logic [2:0] f3,
                                    input int unsigned data_w);
    if (we) return (f3[2] == 1'b0) && ((data_w == 64) || (f3 != SD));
    return (f3 != 3'b111) && ((data_w == 64) || ((f3 != LD) && (f3 != LWU)));
  endfunction

  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [2:0] lo);
    case (f3[1:0])
      2'd0:    return 1'b0;
      2'd1:    return lo[0];
      2'd2:    return |lo[1:0];
      default: return |lo;
    endcase
  endfunction

endpackage

// File: rtl/lsu_axi_ctrl_if.sv
// AXI4-Lite bus bundle between the LSU (master) and the memory fabric (slave).
interface lsu_axi_ctrl_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) ();
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arsize;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awsize;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport master (
    output araddr, arsize, arvalid, rready, awaddr, awsize, awvalid,
           wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arsize, arvalid, rready, awaddr, awsize, awvalid,
           wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store data/strobe placement and load extraction with
// sign or zero extension to the full bus width.
module lsu_lane_align #(
  parameter  int unsigned DATA_W = 32,
  localparam int unsigned STRB_W = DATA_W / 8,
  localparam int unsigned LANE_W = $clog2(STRB_W)
) (
  input  logic [1:0]        size_i,
  input  logic              uns_i,
  input  logic [LANE_W-1:0] offset_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic [DATA_W-1:0] wdata_o,
  output logic [STRB_W-1:0] wstrb_o,
  output logic [DATA_W-1:0] rdata_o
);

  logic [LANE_W+2:0] shamt;
  logic [DATA_W-1:0] rshift;
  logic [DATA_W-1:0] keep;
  logic [STRB_W-1:0] mask;
  logic              sign;

  assign shamt   = {offset_i, 3'b000};
  assign wdata_o = wdata_i << shamt;
  assign rshift  = rdata_i >> shamt;

  // NOTE: every output of this block gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    mask = '1;
    keep = '1;
    sign = rshift[DATA_W-1];
    unique case (size_i)
      2'd0: begin mask = STRB_W'(1);     keep = DATA_W'(8'hff);         sign = rshift[7];  end
      2'd1: begin mask = STRB_W'(3);     keep = DATA_W'(16'hffff);      sign = rshift[15]; end
      2'd2: begin mask = STRB_W'(4'hf);  keep = DATA_W'(32'hffff_ffff); sign = rshift[31]; end
      default: ;
    endcase
  end

  assign wstrb_o = mask << offset_i;
  assign rdata_o = (rshift & keep) | ((~uns_i & sign) ? ~keep : '0);

endmodule

// File: rtl/lsu_axi_ctrl.sv
// Load/store unit: registers one EXU request and runs it as a single
// AXI4-Lite transaction, returning a one-cycle response pulse to the WBU.
module lsu_axi_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned        DATA_W   = 32,
  parameter int unsigned        ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  FW_BASE  = ADDR_W'(32'h0f00_0000),
  parameter logic [ADDR_W-1:0]  FW_LIMIT = ADDR_W'(32'h1000_0000)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_misalign,
  lsu_axi_ctrl_if.master    axi
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned LANE_W = $clog2(STRB_W);

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [DATA_W-1:0] wdata_q;
  logic              req_ready_q, arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;
  logic              rsp_valid_q, rsp_err_q, rsp_misalign_q;
  logic [DATA_W-1:0] rsp_rdata_q;

  logic              in_fw;
  logic [LANE_W-1:0] lane_off;
  logic [ADDR_W-1:0] bus_addr;
  logic [2:0]        bus_size;
  logic [DATA_W-1:0] wdata_al, rdata_ext;
  logic [STRB_W-1:0] wstrb_al;
  logic              aw_fire, w_fire;

  // Inside the full-width window the slave only sees bus-aligned full-size beats.
  assign in_fw    = (addr_q >= FW_BASE) && (addr_q < FW_LIMIT);
  assign lane_off = in_fw ? addr_q[LANE_W-1:0] : '0;
  assign bus_addr = in_fw ? {addr_q[ADDR_W-1:LANE_W], {LANE_W{1'b0}}} : addr_q;
  assign bus_size = in_fw ? 3'(LANE_W) : {1'b0, f3_q[1:0]};
  assign aw_fire  = awvalid_q & axi.awready;
  assign w_fire   = wvalid_q & axi.wready;

  lsu_lane_align #(.DATA_W(DATA_W)) u_lane_align (
    .size_i   (f3_q[1:0]),
    .uns_i    (f3_q[2]),
    .offset_i (lane_off),
    .wdata_i  (wdata_q),
    .rdata_i  (axi.rdata),
    .wdata_o  (wdata_al),
    .wstrb_o  (wstrb_al),
    .rdata_o  (rdata_ext)
  );

  // NOTE: all state here is updated with <= so every register samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      addr_q         <= '0;
      we_q           <= 1'b0;
      f3_q           <= '0;
      wdata_q        <= '0;
      req_ready_q    <= 1'b0;
      arvalid_q      <= 1'b0;
      rready_q       <= 1'b0;
      awvalid_q      <= 1'b0;
      wvalid_q       <= 1'b0;
      bready_q       <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_rdata_q    <= '0;
      rsp_err_q      <= 1'b0;
      rsp_misalign_q <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          req_ready_q <= 1'b1;
          if (req_valid && req_ready_q) begin
            req_ready_q    <= 1'b0;
            addr_q         <= req_addr;
            we_q           <= req_we;
            f3_q           <= req_funct3;
            wdata_q        <= req_wdata;
            rsp_rdata_q    <= '0;
            rsp_err_q      <= 1'b0;
            rsp_misalign_q <= 1'b0;
            if (!f3_legal(req_we, req_funct3, DATA_W)) begin
              rsp_err_q   <= 1'b1;
              rsp_valid_q <= 1'b1;
              state_q     <= S_RSP;
            end else if (f3_misaligned(req_funct3, req_addr[2:0])) begin
              rsp_misalign_q <= 1'b1;
              rsp_valid_q    <= 1'b1;
              state_q        <= S_RSP;
            end else if (req_we) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= S_AWW;
            end else begin
              arvalid_q <= 1'b1;
              state_q   <= S_AR;
            end
          end
        end
        S_AR: if (axi.arready) begin
          arvalid_q <= 1'b0;
          rready_q  <= 1'b1;
          state_q   <= S_R;
        end
        S_R: if (axi.rvalid) begin
          rready_q    <= 1'b0;
          rsp_err_q   <= (axi.rresp != RESP_OKAY);
          rsp_rdata_q <= (axi.rresp == RESP_OKAY) ? rdata_ext : '0;
          rsp_valid_q <= 1'b1;
          state_q     <= S_RSP;
        end
        S_AWW: begin
          if (aw_fire) awvalid_q <= 1'b0;
          if (w_fire)  wvalid_q  <= 1'b0;
          if ((!awvalid_q || aw_fire) && (!wvalid_q || w_fire)) begin
            bready_q <= 1'b1;
            state_q  <= S_B;
          end
        end
        S_B: if (axi.bvalid) begin
          bready_q    <= 1'b0;
          rsp_err_q   <= (axi.bresp != RESP_OKAY);
          rsp_valid_q <= 1'b1;
          state_q     <= S_RSP;
        end
        S_RSP: begin
          req_ready_q <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready    = req_ready_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign rsp_err      = rsp_err_q;
  assign rsp_misalign = rsp_misalign_q;

  assign axi.araddr  = bus_addr;
  assign axi.arsize  = bus_size;
  assign axi.arvalid = arvalid_q;
  assign axi.rready  = rready_q;
  assign axi.awaddr  = bus_addr;
  assign axi.awsize  = bus_size;
  assign axi.awvalid = awvalid_q;
  assign axi.wdata   = wdata_al;
  assign axi.wstrb   = wstrb_al;
  assign axi.wvalid  = wvalid_q;
  assign axi.bready  = bready_q;

  logic unused_we;
  assign unused_we = we_q;

endmodule

// File: tb/tb_lsu_axi_ctrl.sv
// Directed bench for lsu_axi_ctrl: a 32-bit and a 64-bit instance share one
// request/slave stimulus; sel64 picks which instance is driven and observed.
module tb_lsu_axi_ctrl;
  import lsu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic        sel64;
  logic        req_valid, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;
  logic        s_arready, s_rvalid, s_awready, s_wready, s_bvalid;
  logic [63:0] s_rdata;
  logic [1:0]  s_rresp, s_bresp;

  lsu_axi_ctrl_if #(.ADDR_W(32), .DATA_W(32)) axi32 ();
  lsu_axi_ctrl_if #(.ADDR_W(32), .DATA_W(64)) axi64 ();

  assign axi32.arready = s_arready;  assign axi64.arready = s_arready;
  assign axi32.rvalid  = s_rvalid;   assign axi64.rvalid  = s_rvalid;
  assign axi32.rdata   = s_rdata[31:0];
  assign axi64.rdata   = s_rdata;
  assign axi32.rresp   = s_rresp;    assign axi64.rresp   = s_rresp;
  assign axi32.awready = s_awready;  assign axi64.awready = s_awready;
  assign axi32.wready  = s_wready;   assign axi64.wready  = s_wready;
  assign axi32.bvalid  = s_bvalid;   assign axi64.bvalid  = s_bvalid;
  assign axi32.bresp   = s_bresp;    assign axi64.bresp   = s_bresp;

  logic        req_ready32, rsp_valid32, rsp_err32, rsp_mis32;
  logic [31:0] rsp_rdata32;
  logic        req_ready64, rsp_valid64, rsp_err64, rsp_mis64;
  logic [63:0] rsp_rdata64;

  lsu_axi_ctrl #(.DATA_W(32)) u_dut32 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid & ~sel64), .req_ready(req_ready32), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata[31:0]),
    .rsp_valid(rsp_valid32), .rsp_rdata(rsp_rdata32), .rsp_err(rsp_err32),
    .rsp_misalign(rsp_mis32), .axi(axi32)
  );

  lsu_axi_ctrl #(.DATA_W(64)) u_dut64 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid & sel64), .req_ready(req_ready64), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid64), .rsp_rdata(rsp_rdata64), .rsp_err(rsp_err64),
    .rsp_misalign(rsp_mis64), .axi(axi64)
  );

  logic        o_req_ready, o_rsp_valid, o_rsp_err, o_rsp_mis;
  logic [63:0] o_rsp_rdata, o_wdata;
  logic        o_arvalid, o_rready, o_awvalid, o_wvalid, o_bready;
  logic [31:0] o_araddr, o_awaddr;
  logic [2:0]  o_arsize, o_awsize;
  logic [7:0]  o_wstrb;

  assign o_req_ready = sel64 ? req_ready64 : req_ready32;
  assign o_rsp_valid = sel64 ? rsp_valid64 : rsp_valid32;
  assign o_rsp_err   = sel64 ? rsp_err64   : rsp_err32;
  assign o_rsp_mis   = sel64 ? rsp_mis64   : rsp_mis32;
  assign o_rsp_rdata = sel64 ? rsp_rdata64 : {32'h0, rsp_rdata32};
  assign o_arvalid   = sel64 ? axi64.arvalid : axi32.arvalid;
  assign o_araddr    = sel64 ? axi64.araddr  : axi32.araddr;
  assign o_arsize    = sel64 ? axi64.arsize  : axi32.arsize;
  assign o_rready    = sel64 ? axi64.rready  : axi32.rready;
  assign o_awvalid   = sel64 ? axi64.awvalid : axi32.awvalid;
  assign o_awaddr    = sel64 ? axi64.awaddr  : axi32.awaddr;
  assign o_awsize    = sel64 ? axi64.awsize  : axi32.awsize;
  assign o_wvalid    = sel64 ? axi64.wvalid  : axi32.wvalid;
  assign o_wdata     = sel64 ? axi64.wdata   : {32'h0, axi32.wdata};
  assign o_wstrb     = sel64 ? axi64.wstrb   : {4'h0, axi32.wstrb};
  assign o_bready    = sel64 ? axi64.bready  : axi32.bready;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [63:0] wdata);
    int k = 0;
    while (o_req_ready !== 1'b1 && k < 16) begin
      tick();
      k++;
    end
    check("req_ready", o_req_ready, 1'b1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    tick();
    req_valid = 1'b0; req_wdata = '0;
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                         input int ar_wait, input logic [63:0] rdata, input logic [1:0] rresp,
                         input logic [31:0] exp_addr, input logic [2:0] exp_size,
                         input logic [63:0] exp_data, input logic exp_err);
    send(1'b0, f3, addr, '0);
    check({tag, ".arvalid"}, o_arvalid, 1'b1);
    check({tag, ".araddr"},  o_araddr,  exp_addr);
    check({tag, ".arsize"},  o_arsize,  exp_size);
    for (int i = 0; i < ar_wait; i++) begin
      tick();
      check({tag, ".ar_hold"}, {o_arvalid, o_araddr}, {1'b1, exp_addr});
    end
    s_arready = 1'b1;
    tick();
    s_arready = 1'b0;
    check({tag, ".r_phase"}, {o_arvalid, o_rready, o_rsp_valid}, 3'b010);
    s_rvalid = 1'b1; s_rdata = rdata; s_rresp = rresp;
    tick();
    s_rvalid = 1'b0; s_rresp = RESP_OKAY;
    check({tag, ".rsp_valid"}, {o_rsp_valid, o_rready}, 2'b10);
    check({tag, ".rdata"},     o_rsp_rdata, exp_data);
    check({tag, ".err_mis"},   {o_rsp_err, o_rsp_mis}, {exp_err, 1'b0});
    tick();
    check({tag, ".rsp_pulse"}, o_rsp_valid, 1'b0);
  endtask

  task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [63:0] wdata, input int aw_d, input int w_d,
                          input logic [1:0] bresp, input logic [31:0] exp_addr,
                          input logic [2:0] exp_size, input logic [63:0] exp_wdata,
                          input logic [7:0] exp_strb, input logic exp_err);
    int last;
    last = (aw_d > w_d) ? aw_d : w_d;
    send(1'b1, f3, addr, wdata);
    check({tag, ".valids"}, {o_awvalid, o_wvalid, o_arvalid}, 3'b110);
    check({tag, ".awaddr"}, o_awaddr,  exp_addr);
    check({tag, ".awsize"}, o_awsize,  exp_size);
    check({tag, ".wdata"},  o_wdata,   exp_wdata);
    check({tag, ".wstrb"},  o_wstrb,   exp_strb);
    for (int c = 0; c <= last; c++) begin
      s_awready = (c == aw_d);
      s_wready  = (c == w_d);
      tick();
      check({tag, ".aww_step"}, {o_awvalid, o_wvalid, o_bready},
            {(c < aw_d), (c < w_d), (c == last)});
    end
    s_awready = 1'b0; s_wready = 1'b0;
    check({tag, ".b_wait"}, o_rsp_valid, 1'b0);
    s_bvalid = 1'b1; s_bresp = bresp;
    tick();
    s_bvalid = 1'b0; s_bresp = RESP_OKAY;
    check({tag, ".rsp"}, {o_rsp_valid, o_rsp_err, o_rsp_mis, o_bready}, {1'b1, exp_err, 2'b00});
    check({tag, ".rdata"}, o_rsp_rdata, 64'h0);
    tick();
    check({tag, ".rsp_pulse"}, o_rsp_valid, 1'b0);
  endtask

  task automatic do_early(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic exp_err, input logic exp_mis);
    send(we, f3, addr, 64'h55);
    check({tag, ".no_bus"}, {o_arvalid, o_awvalid, o_wvalid}, 3'b000);
    check({tag, ".rsp"}, {o_rsp_valid, o_rsp_err, o_rsp_mis}, {1'b1, exp_err, exp_mis});
    check({tag, ".rdata"}, o_rsp_rdata, 64'h0);
    tick();
    check({tag, ".rsp_pulse"}, {o_rsp_valid, o_arvalid, o_awvalid}, 3'b000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    sel64 = 1'b0; rst = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
    s_arready = 1'b0; s_rvalid = 1'b0; s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0;
    s_rdata = '0; s_rresp = RESP_OKAY; s_bresp = RESP_OKAY;
    tick();
    tick();
    check("reset.outputs",
          {o_req_ready, o_arvalid, o_rready, o_awvalid, o_wvalid, o_bready, o_rsp_valid},
          7'b0000000);
    check("reset.rsp", {o_rsp_err, o_rsp_mis, o_rsp_rdata}, 66'h0);
    rst = 1'b1;
    tick();

    // 32-bit bus
    do_load("lbu_fw", LBU, 32'h0f00_0003, 0, 64'hA1B2_C3D4, RESP_OKAY,
            32'h0f00_0000, 3'd2, 64'h0000_00A1, 1'b0);
    do_load("lh_sext", LH, 32'h0f00_0002, 2, 64'h8000_1234, RESP_OKAY,
            32'h0f00_0000, 3'd2, 64'hFFFF_8000, 1'b0);
    do_load("lb_io", LB, 32'h1000_0005, 0, 64'h0000_00F0, RESP_OKAY,
            32'h1000_0005, 3'd0, 64'hFFFF_FFF0, 1'b0);
    do_store("sh_fw", SH, 32'h0f00_0002, 64'h1234, 0, 0, RESP_OKAY,
             32'h0f00_0000, 3'd2, 64'h1234_0000, 8'b0000_1100, 1'b0);
    do_store("sb_uart", SB, 32'h1000_0000, 64'h41, 0, 2, RESP_OKAY,
             32'h1000_0000, 3'd0, 64'h41, 8'b0000_0001, 1'b0);
    do_store("sw_berr", SW, 32'h0f00_0004, 64'hDEAD_BEEF, 1, 0, RESP_SLVERR,
             32'h0f00_0004, 3'd2, 64'hDEAD_BEEF, 8'b0000_1111, 1'b1);
    do_early("lw_mis", 1'b0, LW,     32'h0f00_0002, 1'b0, 1'b1);
    do_early("sh_mis", 1'b1, SH,     32'h0f00_0001, 1'b0, 1'b1);
    do_early("lwu_32", 1'b0, LWU,    32'h0f00_0000, 1'b1, 1'b0);
    do_early("sd_32",  1'b1, SD,     32'h0f00_0000, 1'b1, 1'b0);
    do_early("ld_111", 1'b0, 3'b111, 32'h0f00_0000, 1'b1, 1'b0);
    do_load("lh_rerr", LH, 32'h0f00_0000, 0, 64'h8000, RESP_SLVERR,
            32'h0f00_0000, 3'd2, 64'h0, 1'b1);

    // 64-bit bus
    sel64 = 1'b1;
    #1;
    do_load("ld64", LD, 32'h0f00_0008, 0, 64'h8877_6655_4433_2211, RESP_OKAY,
            32'h0f00_0008, 3'd3, 64'h8877_6655_4433_2211, 1'b0);
    do_load("lw64_hi", LW, 32'h0f00_000c, 0, 64'h8877_6655_4433_2211, RESP_OKAY,
            32'h0f00_0008, 3'd3, 64'hFFFF_FFFF_8877_6655, 1'b0);
    do_store("sh64", SH, 32'h0f00_000e, 64'hBEEF, 0, 0, RESP_OKAY,
             32'h0f00_0008, 3'd3, 64'hBEEF_0000_0000_0000, 8'b1100_0000, 1'b0);

    // Reset while the read address is outstanding
    send(1'b0, LD, 32'h0f00_0000, '0);
    check("rst_ar.arvalid", o_arvalid, 1'b1);
    rst = 1'b0;
    tick();
    check("rst_ar.cleared", {o_arvalid, o_rready, o_rsp_valid, o_req_ready}, 4'b0000);
    rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      seen = seen | o_rsp_valid | o_arvalid;
    end
    check("rst_ar.no_rsp", seen, 1'b0);
    check("rst_ar.idle", o_req_ready, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
